// File: rtl/pipe_stage_skid_if.sv
// Handshake and side-band bundle for one pipe_stage_skid instance.
// slave = the stage itself, master = the surrounding pipeline.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 8,
    parameter int OPC_W  = 3,
    parameter int CTRL_W = 3,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [OPC_W-1:0]  in_opcode;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [OPC_W-1:0]  out_opcode;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
    logic              perf_clr;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    modport slave (
        input  flush, in_valid, in_data, in_opcode, in_ctrl, out_ready, perf_clr,
        output in_ready, out_valid, out_data, out_opcode, out_ctrl, occupancy,
               stall_cnt, bubble_cnt
    );

    modport master (
        output flush, in_valid, in_data, in_opcode, in_ctrl, out_ready, perf_clr,
        input  in_ready, out_valid, out_data, out_opcode, out_ctrl, occupancy,
               stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with 2-entry skid buffer, registered in_ready and flush.
// Define PIPE_STAGE_PERF_CNT_EN to build the stall/bubble performance counters.
module pipe_stage_skid #(
    parameter int DATA_W = 8,
    parameter int OPC_W  = 3,
    parameter int CTRL_W = 3,
    parameter int CNT_W  = 16
) (
    input logic                clk,
    input logic                rst,
    pipe_stage_skid_if.slave   bus
);
    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_FULL = 2'd2} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main_data, r_skid_data;
    logic [OPC_W-1:0]  r_main_opc,  r_skid_opc;
    logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;

    logic w_out_valid, w_in_fire, w_out_fire;
    logic w_ld_main_in, w_ld_main_skid, w_ld_skid;

    assign w_out_valid = (r_state != S_EMPTY);
    assign w_in_fire   = bus.in_valid & r_in_ready;
    assign w_out_fire  = w_out_valid & bus.out_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (bus.flush) begin
            // squash wins: nothing is captured, whatever is held is dropped
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_in_fire) begin
                    w_ld_main_in = 1'b1;
                    w_state_nxt  = S_ONE;
                end
                S_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_ld_skid   = 1'b1;
                        w_state_nxt = S_FULL;
                    end else if (w_out_fire) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: if (w_out_fire) begin
                    w_ld_main_skid = 1'b1;
                    w_state_nxt    = S_ONE;
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // in_ready is a flop copy of (next != FULL) so upstream sees no comb path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_FULL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_data <= '0;
            r_main_opc  <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_opc  <= '0;
            r_skid_ctrl <= '0;
        end else begin
            if (w_ld_main_in) begin
                r_main_data <= bus.in_data;
                r_main_opc  <= bus.in_opcode;
                r_main_ctrl <= bus.in_ctrl;
            end else if (w_ld_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_opc  <= r_skid_opc;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_ld_skid) begin
                r_skid_data <= bus.in_data;
                r_skid_opc  <= bus.in_opcode;
                r_skid_ctrl <= bus.in_ctrl;
            end
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = r_main_data;
    assign bus.out_opcode = r_main_opc;
    assign bus.out_ctrl   = w_out_valid ? r_main_ctrl : '0;
    assign bus.occupancy  = r_state;

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (bus.perf_clr) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_out_valid && !bus.out_ready && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (!w_out_valid && bus.out_ready && !(&r_bubble_cnt))
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.bubble_cnt = r_bubble_cnt;
`else
    logic w_unused_perf_clr;
    assign w_unused_perf_clr = bus.perf_clr;
    assign bus.stall_cnt     = '0;
    assign bus.bubble_cnt    = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed + random bench for pipe_stage_skid with a queue-based scoreboard.
module tb_pipe_stage_skid;
    localparam int DATA_W = 16;
    localparam int OPC_W  = 3;
    localparam int CTRL_W = 4;
    localparam int CNT_W  = 4;
`ifdef PIPE_STAGE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [OPC_W-1:0]  o;
        logic [CTRL_W-1:0] c;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    pipe_stage_skid_if #(.DATA_W(DATA_W), .OPC_W(OPC_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

    pipe_stage_skid #(.DATA_W(DATA_W), .OPC_W(OPC_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                         input logic [OPC_W-1:0] o, input logic [CTRL_W-1:0] c);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_opcode = o;
        bus.in_ctrl   = c;
    endtask

    // Monitor at negedge: the values seen here are what the next posedge samples.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (!bus.out_valid) check("ctrl_gated", {28'd0, bus.out_ctrl}, 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                check("sb_expect_entry", (q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                if (q.size() != 0) begin
                    ent_t e;
                    e = q.pop_front();
                    check("sb_data", {16'd0, bus.out_data}, {16'd0, e.d});
                    check("sb_opcode", {29'd0, bus.out_opcode}, {29'd0, e.o});
                    check("sb_ctrl", {28'd0, bus.out_ctrl}, {28'd0, e.c});
                end
            end
            if (bus.flush) q.delete();
            else if (bus.in_valid && bus.in_ready) begin
                ent_t e;
                e.d = bus.in_data;
                e.o = bus.in_opcode;
                e.c = bus.in_ctrl;
                q.push_back(e);
            end
        end
    end

    initial begin
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        bus.perf_clr  = 1'b0;
        drive(1'b0, '0, '0, '0);

        // reset values
        #2 rst = 1'b1;
        tick(); tick();
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_occ", {30'd0, bus.occupancy}, 32'd0);
        check("rst_out_ctrl", {28'd0, bus.out_ctrl}, 32'd0);
        check("rst_out_data", {16'd0, bus.out_data}, 32'd0);
        check("rst_out_opc", {29'd0, bus.out_opcode}, 32'd0);
        check("rst_stall", {28'd0, bus.stall_cnt}, 32'd0);
        check("rst_bubble", {28'd0, bus.bubble_cnt}, 32'd0);
        rst = 1'b0;
        tick();

        // streaming 0x01..0x10, 1-cycle latency, no gaps
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 16'(i), 3'b101, 4'b0011);
            tick();
            check("stream_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stream_data", {16'd0, bus.out_data}, 32'(i));
        end
        drive(1'b0, '0, '0, '0);
        tick();
        check("stream_drained", {30'd0, bus.occupancy}, 32'd0);

        // backpressure: fill, third input ignored, then drain in order
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h00A5, 3'd1, 4'd1); tick();
        drive(1'b1, 16'h005A, 3'd2, 4'd2); tick();
        check("bp_occ_full", {30'd0, bus.occupancy}, 32'd2);
        check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        drive(1'b1, 16'h00FF, 3'd3, 4'd3); tick();
        check("bp_occ_hold", {30'd0, bus.occupancy}, 32'd2);
        check("bp_head", {16'd0, bus.out_data}, 32'h00A5);
        drive(1'b0, '0, '0, '0);
        bus.out_ready = 1'b1;
        tick();
        check("bp_second", {16'd0, bus.out_data}, 32'h005A);
        check("bp_occ_one", {30'd0, bus.occupancy}, 32'd1);
        tick();
        check("bp_occ_empty", {30'd0, bus.occupancy}, 32'd0);

        // flush in FULL while 0x77 is offered
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h0011, 3'd4, 4'hF); tick();
        drive(1'b1, 16'h0022, 3'd5, 4'hF); tick();
        drive(1'b1, 16'h0077, 3'd6, 4'hF);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        check("fl_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("fl_out_ctrl", {28'd0, bus.out_ctrl}, 32'd0);
        check("fl_occ", {30'd0, bus.occupancy}, 32'd0);
        check("fl_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_no_77", {31'd0, bus.out_valid}, 32'd0);
        end

        // asynchronous reset with two entries held
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h0033, 3'd1, 4'h7); tick();
        drive(1'b1, 16'h0044, 3'd2, 4'h7); tick();
        drive(1'b0, '0, '0, '0);
        check("ar_occ_before", {30'd0, bus.occupancy}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("ar_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("ar_out_ctrl", {28'd0, bus.out_ctrl}, 32'd0);
        check("ar_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("ar_occ", {30'd0, bus.occupancy}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // random valid/ready with occasional flush
        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom), 4'($urandom));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.flush     = ($urandom_range(0, 63) == 0);
            tick();
        end
        bus.flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        bus.out_ready = 1'b1;
        tick(); tick(); tick();
        check("rnd_sb_empty", 32'(q.size()), 32'd0);
        check("rnd_occ", {30'd0, bus.occupancy}, 32'd0);

        // performance counters
        bus.out_ready = 1'b0;
        bus.perf_clr  = 1'b1;
        drive(1'b1, 16'h0055, 3'd1, 4'd1); tick();
        drive(1'b0, '0, '0, '0);
        tick();
        bus.perf_clr = 1'b0;
        repeat (5) tick();
        check("pc_stall5", {28'd0, bus.stall_cnt}, PERF ? 32'd5 : 32'd0);
        check("pc_bubble0", {28'd0, bus.bubble_cnt}, 32'd0);
        bus.out_ready = 1'b1;
        tick();
        repeat (3) tick();
        check("pc_stall_hold", {28'd0, bus.stall_cnt}, PERF ? 32'd5 : 32'd0);
        check("pc_bubble3", {28'd0, bus.bubble_cnt}, PERF ? 32'd3 : 32'd0);
        bus.perf_clr = 1'b1;
        tick();
        bus.perf_clr = 1'b0;
        check("pc_clr_stall", {28'd0, bus.stall_cnt}, 32'd0);
        check("pc_clr_bubble", {28'd0, bus.bubble_cnt}, 32'd0);
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h0066, 3'd2, 4'd2); tick();
        drive(1'b0, '0, '0, '0);
        repeat (20) tick();
        check("pc_sat", {28'd0, bus.stall_cnt}, PERF ? 32'd15 : 32'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("pc_flush_keeps", {28'd0, bus.stall_cnt}, PERF ? 32'd15 : 32'd0);
        check("pc_flush_occ", {30'd0, bus.occupancy}, 32'd0);
        check("pc_bubble_none", {28'd0, bus.bubble_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register for the accumulator CPU; replaces fixed-width stage latches between pipeline stages.
- Carries data, opcode and a control-enable bundle (e.g. mem_we, acc_we, acc_control) with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready. Supports synchronous flush for branch/hazard squash.

Parameters:
- DATA_W, 8, width of data payload
- OPC_W, 3, width of opcode field
- CTRL_W, 3, width of control-enable bundle; bit i is a write/enable strobe
- CNT_W, 16, width of performance counters (optional feature only)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered
- in_data  in  DATA_W  payload
- in_opcode  in  OPC_W  opcode
- in_ctrl  in  CTRL_W  control enables
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_data  out  DATA_W  head payload
- out_opcode  out  OPC_W  head opcode
- out_ctrl  out  CTRL_W  head enables, forced 0 when out_valid=0
- occupancy  out  2  entries held (0..2)
- perf_clr  in  1  synchronous clear of counters
- stall_cnt  out  CNT_W  cycles with out_valid & ~out_ready
- bubble_cnt  out  CNT_W  cycles with ~out_valid & out_ready

Behaviour:
- Storage: main register (drives outputs) plus skid register. in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset: all valid bits 0. out_valid=0, in_ready=1, occupancy=0. out_data, out_opcode, out_ctrl all 0. Counters 0.
- States: EMPTY (occ 0), ONE (main valid), FULL (main+skid valid). in_ready = (state != FULL), from a flop.
- EMPTY: in_fire -> main<=in, ONE; else stay.
- ONE:
  - in_fire & out_fire -> main<=in, stay ONE.
  - in_fire only -> skid<=in, FULL.
  - out_fire only -> EMPTY.
- FULL: in_ready=0, so input is ignored. out_fire -> main<=skid, ONE; else hold.
- Latency: 1 cycle from in_fire to out_valid when EMPTY or when head leaves the same cycle.
- Throughput: 1 entry/cycle sustained. Entries never reorder, duplicate or drop except on flush.
- Flush has highest priority over any in_fire/out_fire that cycle:
  - Next state is EMPTY and the input that cycle is discarded.
  - out_fire in a flush cycle still counts as consumed downstream.
  - in_ready=1 the cycle after flush.
- out_ctrl is gated by out_valid, so a bubble never asserts write enables. out_data and out_opcode hold their last value when invalid.
- Payload registers load only on the fire events above; no enable-free capture.
- Reset mid-transfer: immediate return to reset values; no entry survives.

Optional Feature:
- Macro PIPE_STAGE_PERF_CNT_EN.
- Defined:
  - stall_cnt and bubble_cnt increment per their conditions and saturate at all-ones.
  - perf_clr zeroes both next cycle and wins over increment.
  - Counters are unaffected by flush.
- Undefined: counter flops are not built; stall_cnt and bubble_cnt are tied to 0 and perf_clr is ignored. Ports stay present.

Test Plan:
- Reset: assert rst mid-stream with occ=2 -> out_valid=0, out_ctrl=0, in_ready=1, occupancy=0 asynchronously.
- Streaming: out_ready=1, feed data 0x01..0x10 back-to-back with opcode=3'b101, ctrl=3'b011 -> identical sequence out, 1-cycle latency, no gaps.
- Backpressure:
  - out_ready=0, push 0xA5 then 0x5A -> occupancy=2, in_ready=0 next cycle, third input 0xFF ignored.
  - Then out_ready=1 -> 0xA5, 0x5A emerge in order.
- Flush in FULL with in_valid=1 (0x77) -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 0x77 never appears.
- Random valid/ready: 1000 cycles, DATA_W=16, CTRL_W=4 -> scoreboard order match; out_ctrl=0 whenever out_valid=0.
- Perf counters (macro defined): 5 stall cycles then 3 bubble cycles -> stall_cnt=5, bubble_cnt=3; perf_clr -> both 0. With CNT_W=4 and 20 stalls -> stall_cnt=15.
